itch_msg_asm: RTL and testbench
===============================

# itch_msg_asm

Parametrised ITCH message reassembler: takes the byte-aligned payload beats produced by the MoldUDP64 depacketizer, including the overlap lane that carries the start of the next message in the same beat, and rebuilds each complete ITCH message into a flat byte buffer. It sits between the mold layer and the per-type ITCH field decoders. It generalises the fixed 64-bit, single-message-per-cycle decode path to configurable beat width and maximum message size. It adds length checking, error reporting and a 2-entry output queue for beats that complete two messages.

## Interface
- DATA_W, 64, payload beat width in bits; 64 or 128
- LEN, 8, bits per byte
- MAX_MSG_BYTES, 50, largest accepted message, type byte included
- OV_DATA_W, DATA_W-2*LEN, overlap lane width (mold 2-byte length header removed)
- KEEP_LW / OV_KEEP_LW, derived, $clog2(bytes+1)
- Clocking: one clock; reset is synchronous and active-high
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_i  in  1  data lane beat valid
- start_i  in  1  data lane begins a new message at byte 0
- len_i  in  KEEP_LW  valid bytes in data_i, low bytes first, 1..DATA_W/8
- data_i  in  DATA_W  payload bytes, byte 0 in bits [7:0]
- msg_len_i  in  16  mold length of the message starting this beat; sampled when start_i
- ov_valid_i  in  1  overlap lane carries the start of the next message
- ov_len_i  in  OV_KEEP_LW  valid bytes in ov_data_i, 1..OV_DATA_W/8
- ov_data_i  in  OV_DATA_W  overlap bytes
- ov_msg_len_i  in  16  mold length of the overlap message
- msg_valid_o  out  1  one-cycle pulse: message on outputs
- msg_type_o  out  8  byte 0 of the message
- msg_len_o  out  $clog2(MAX_MSG_BYTES+1)  message length in bytes
- msg_data_o  out  MAX_MSG_BYTES*LEN  message bytes; bytes beyond msg_len_o are zero
- err_o  out  1  one-cycle error pulse
- err_code_o  out  3  1 OVERSIZE, 2 TRUNC, 3 OVERRUN, 4 OV_ILLEGAL, 5 QFULL; 0 otherwise

## Operation
- Assembly FSM: IDLE, ACC, DROP. Byte counter cnt, expected length exp.
- IDLE + valid_i + start_i: the block checks msg_len_i. If it is 0 or greater than MAX_MSG_BYTES, it raises OVERSIZE and moves to DROP. Otherwise it sets exp = msg_len_i, writes the bytes at offset 0 and sets cnt = len_i.
- ACC + valid_i + !start_i: the block writes the bytes at offset cnt and sets cnt += len_i.
- Completion when cnt_new == exp. The message is pushed to the output queue, the buffer is cleared and the FSM returns to IDLE.
- cnt_new > exp: OVERRUN. The message is discarded and the FSM goes to IDLE.
- start_i in ACC: TRUNC. The partial message is discarded and the new message is loaded as from IDLE.
- valid_i without start_i in IDLE: the beat is ignored silently. In DROP, beats are ignored until start_i.
- Overlap lane:
  - ov_valid_i is legal only on a beat that completes the current message. Otherwise it raises OV_ILLEGAL and the overlap lane is ignored.
  - On a legal ov_valid_i, the overlap message loads as a new start: exp = ov_msg_len_i, cnt = ov_len_i. The same OVERSIZE check applies.
  - If ov_len_i == ov_msg_len_i, the overlap message also completes and is pushed after the data-lane message. This is only possible when DATA_W=128.
- Output queue: 2 entries, FIFO order. One pop per cycle onto the registered outputs.
  - A push into a full queue drops the new message and raises QFULL.
  - Errors raised in the same cycle are prioritised OVERSIZE > TRUNC > OVERRUN > OV_ILLEGAL > QFULL. Only one code is reported per cycle.
- Reset: FSM IDLE, cnt=0, queue empty, all outputs 0. Reset mid-message discards the partial message and produces no output or error.

## Timing
- msg_valid_o is asserted 1 cycle after the completing beat when the queue is empty.
- For a double completion, the second message appears the cycle after the first.
- Errors are registered and appear 1 cycle after the offending beat.
- Throughput: 1 beat per cycle, no backpressure. valid_i gaps are allowed mid-message.

## Test plan
- 21-byte message "G" + 20×FF over beats of 8,8,5, then overlap "A" (ov_len 1, ov_msg_len 36) followed by AA,BB,CC,DD ×8 and EE×3. Required response:
  - msg_valid_o at cycle 4 with msg_type_o="G", msg_len_o=21.
  - A second pulse 1 cycle after the EE beat with msg_type_o="A", msg_len_o=36 and bytes in order.
- msg_len_i=51 on start (MAX 50) -> err_code_o=1 next cycle. The following beats produce no msg_valid_o. The next start_i with msg_len_i=12 assembles normally.
- start_i during ACC at cnt=16 of 36 -> TRUNC. Only the new message is output.
- exp=12, beats of 8 then 8 -> OVERRUN on the second beat, no output.
- DATA_W=128: a 12-byte message completes on the data lane and a 12-byte message completes entirely on the overlap lane (ov_len 12). The two msg_valid_o pulses come on consecutive cycles in order. Repeating the pattern on the next two cycles -> QFULL on the fourth push.
- reset asserted mid-message -> outputs 0 on the following cycle. A fresh 12-byte message then completes with cnt starting at 0.

Source files
------------

// File: rtl/itch_msg_asm_if.sv
// Mold-side payload beats into the ITCH reassembler and flat messages out to the decoders.
// valid_i qualifies one beat per cycle; there is no ready, so every valid beat is consumed.
interface itch_msg_asm_if #(
  parameter int DATA_W        = 64,
  parameter int LEN           = 8,
  parameter int MAX_MSG_BYTES = 50,
  parameter int OV_DATA_W     = DATA_W - 2*LEN
);
  localparam int KEEP_LW    = $clog2(DATA_W/LEN + 1);
  localparam int OV_KEEP_LW = $clog2(OV_DATA_W/LEN + 1);
  localparam int ML_W       = $clog2(MAX_MSG_BYTES + 1);

  logic                         valid_i;
  logic                         start_i;
  logic [KEEP_LW-1:0]           len_i;
  logic [DATA_W-1:0]            data_i;
  logic [15:0]                  msg_len_i;
  logic                         ov_valid_i;
  logic [OV_KEEP_LW-1:0]        ov_len_i;
  logic [OV_DATA_W-1:0]         ov_data_i;
  logic [15:0]                  ov_msg_len_i;
  logic                         msg_valid_o;
  logic [7:0]                   msg_type_o;
  logic [ML_W-1:0]              msg_len_o;
  logic [MAX_MSG_BYTES*LEN-1:0] msg_data_o;
  logic                         err_o;
  logic [2:0]                   err_code_o;

  modport master (
    output valid_i, start_i, len_i, data_i, msg_len_i,
           ov_valid_i, ov_len_i, ov_data_i, ov_msg_len_i,
    input  msg_valid_o, msg_type_o, msg_len_o, msg_data_o, err_o, err_code_o
  );

  modport slave (
    input  valid_i, start_i, len_i, data_i, msg_len_i,
           ov_valid_i, ov_len_i, ov_data_i, ov_msg_len_i,
    output msg_valid_o, msg_type_o, msg_len_o, msg_data_o, err_o, err_code_o
  );
endinterface

// File: rtl/itch_msg_asm.sv
// ITCH message reassembler: stitches mold payload beats (plus the overlap lane) into
// flat message buffers, checks lengths, and emits messages through a 2-deep queue.
module itch_msg_asm #(
  parameter int DATA_W        = 64,
  parameter int LEN           = 8,
  parameter int MAX_MSG_BYTES = 50,
  parameter int OV_DATA_W     = DATA_W - 2*LEN
) (
  input  logic           clk,
  input  logic           reset,
  itch_msg_asm_if.slave  bus,
  output logic [1:0]     dbg_state
);
  localparam int BYTES = DATA_W/LEN;
  localparam int BUF_W = MAX_MSG_BYTES*LEN;
  localparam int ML_W  = $clog2(MAX_MSG_BYTES + 1);

  localparam logic [2:0] E_OVERSIZE = 3'd1, E_TRUNC = 3'd2, E_OVERRUN = 3'd3,
                         E_OV_ILL = 3'd4, E_QFULL = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DROP = 2'd2} state_t;

  state_t           state, state_next;
  logic [15:0]      cnt, cnt_next, exp_len, exp_next, cnt_new;
  logic [BUF_W-1:0] buf_q, buf_next, wbuf, obuf;
  logic             data_ok, push0, push1;
  logic             f_oversize, f_trunc, f_overrun, f_ov_ill, f_qfull;
  logic [2:0]       err_code_next;

  // One queued message waits here while the other is on the registered outputs.
  logic             hold_v, s0_v, s1_v;
  logic [ML_W-1:0]  hold_len, s0_len, s1_len;
  logic [BUF_W-1:0] hold_data, s0_data, s1_data;

  function automatic logic [BUF_W-1:0] put_bytes(input logic [BUF_W-1:0] base,
                                                 input logic [DATA_W-1:0] d,
                                                 input int off, input int n);
    logic [BUF_W-1:0] r;
    r = base;
    for (int i = 0; i < BYTES; i++)
      if (i < n && off + i < MAX_MSG_BYTES) r[(off+i)*LEN +: LEN] = d[i*LEN +: LEN];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      exp_len          <= '0;
      buf_q            <= '0;
      hold_v           <= 1'b0;
      hold_len         <= '0;
      hold_data        <= '0;
      bus.msg_valid_o  <= 1'b0;
      bus.msg_type_o   <= '0;
      bus.msg_len_o    <= '0;
      bus.msg_data_o   <= '0;
      bus.err_o        <= 1'b0;
      bus.err_code_o   <= '0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      exp_len          <= exp_next;
      buf_q            <= buf_next;
      hold_v           <= s1_v;
      hold_len         <= s1_len;
      hold_data        <= s1_data;
      bus.msg_valid_o  <= s0_v;
      bus.msg_type_o   <= s0_data[7:0];
      bus.msg_len_o    <= s0_len;
      bus.msg_data_o   <= s0_data;
      bus.err_o        <= (err_code_next != 3'd0);
      bus.err_code_o   <= err_code_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    exp_next   = exp_len;
    buf_next   = buf_q;
    cnt_new    = cnt;
    wbuf       = buf_q;
    data_ok    = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    f_oversize = 1'b0;
    f_trunc    = 1'b0;
    f_overrun  = 1'b0;
    f_ov_ill   = 1'b0;
    obuf       = put_bytes('0, DATA_W'(bus.ov_data_i), 0, int'(bus.ov_len_i));
    if (bus.valid_i) begin
      if (bus.start_i) begin
        f_trunc = (state == ACC);
        if (bus.msg_len_i == 16'd0 || bus.msg_len_i > 16'(MAX_MSG_BYTES)) begin
          f_oversize = 1'b1;
          state_next = DROP;
          cnt_next   = '0;
          exp_next   = '0;
          buf_next   = '0;
        end else begin
          data_ok  = 1'b1;
          exp_next = bus.msg_len_i;
          cnt_new  = 16'(bus.len_i);
          wbuf     = put_bytes('0, bus.data_i, 0, int'(bus.len_i));
        end
      end else if (state == ACC) begin
        data_ok = 1'b1;
        cnt_new = cnt + 16'(bus.len_i);
        wbuf    = put_bytes(buf_q, bus.data_i, int'(cnt), int'(bus.len_i));
      end
    end
    if (data_ok) begin
      state_next = ACC;
      cnt_next   = cnt_new;
      buf_next   = wbuf;
      if (cnt_new >= exp_next) begin
        push0      = (cnt_new == exp_next);
        f_overrun  = (cnt_new != exp_next);
        state_next = IDLE;
        cnt_next   = '0;
        exp_next   = '0;
        buf_next   = '0;
      end
    end
    // The overlap lane only opens a message when the data lane just closed one.
    if (bus.ov_valid_i) begin
      if (!push0) begin
        f_ov_ill = 1'b1;
      end else if (bus.ov_msg_len_i == 16'd0 || bus.ov_msg_len_i > 16'(MAX_MSG_BYTES)) begin
        f_oversize = 1'b1;
        state_next = DROP;
      end else if (16'(bus.ov_len_i) == bus.ov_msg_len_i) begin
        push1 = 1'b1;
      end else if (16'(bus.ov_len_i) > bus.ov_msg_len_i) begin
        f_overrun = 1'b1;
      end else begin
        state_next = ACC;
        cnt_next   = 16'(bus.ov_len_i);
        exp_next   = bus.ov_msg_len_i;
        buf_next   = obuf;
      end
    end
  end

  // Occupancy is judged before this cycle's pop; slot 0 goes out, slot 1 is held.
  always_comb begin
    f_qfull = 1'b0;
    s1_v    = 1'b0;
    s1_len  = '0;
    s1_data = '0;
    if (hold_v) begin
      s0_v    = 1'b1;
      s0_len  = hold_len;
      s0_data = hold_data;
      if (push0) begin
        s1_v    = 1'b1;
        s1_len  = cnt_new[ML_W-1:0];
        s1_data = wbuf;
      end else if (push1) begin
        s1_v    = 1'b1;
        s1_len  = ML_W'(bus.ov_len_i);
        s1_data = obuf;
      end
      f_qfull = push0 && push1;
    end else begin
      s0_v    = push0 || push1;
      s0_len  = push0 ? cnt_new[ML_W-1:0] : (push1 ? ML_W'(bus.ov_len_i) : '0);
      s0_data = push0 ? wbuf : (push1 ? obuf : '0);
      if (push0 && push1) begin
        s1_v    = 1'b1;
        s1_len  = ML_W'(bus.ov_len_i);
        s1_data = obuf;
      end
    end
  end

  always_comb begin
    dbg_state = state;
    if (f_oversize)    err_code_next = E_OVERSIZE;
    else if (f_trunc)  err_code_next = E_TRUNC;
    else if (f_overrun) err_code_next = E_OVERRUN;
    else if (f_ov_ill) err_code_next = E_OV_ILL;
    else if (f_qfull)  err_code_next = E_QFULL;
    else               err_code_next = 3'd0;
  end
endmodule

// File: tb/tb_itch_msg_asm.sv
// Directed bench for itch_msg_asm: 64-bit instance for assembly/error paths,
// 128-bit instance for double completion and queue overflow.
module tb_itch_msg_asm;
  localparam int MAXB = 50;
  localparam int BW   = MAXB*8;
  localparam int MLW  = 6;
  localparam int OW   = 1 + 8 + MLW + BW;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] st64, st128;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  itch_msg_asm_if #(.DATA_W(64))  b64 ();
  itch_msg_asm_if #(.DATA_W(128)) b128 ();

  itch_msg_asm #(.DATA_W(64))  u64  (.clk(clk), .reset(reset), .bus(b64.slave),  .dbg_state(st64));
  itch_msg_asm #(.DATA_W(128)) u128 (.clk(clk), .reset(reset), .bus(b128.slave), .dbg_state(st128));

  function automatic logic [OW-1:0] obs64();
    return {b64.msg_valid_o, b64.msg_type_o, b64.msg_len_o, b64.msg_data_o};
  endfunction

  function automatic logic [OW-1:0] obs128();
    return {b128.msg_valid_o, b128.msg_type_o, b128.msg_len_o, b128.msg_data_o};
  endfunction

  function automatic logic [OW-1:0] exp_msg(input bq_t q);
    logic [BW-1:0] d;
    d = '0;
    foreach (q[i]) d[i*8 +: 8] = q[i];
    return {1'b1, q[0], MLW'(q.size()), d};
  endfunction

  function automatic bq_t mk12(input logic [7:0] t, input logic [7:0] s);
    bq_t q;
    q.push_back(t);
    for (int i = 1; i < 12; i++) q.push_back(s + 8'(i));
    return q;
  endfunction

  function automatic logic [127:0] pack128(input bq_t q);
    logic [127:0] d;
    d = '0;
    foreach (q[i]) d[i*8 +: 8] = q[i];
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b64.valid_i = 1'b0;  b64.start_i = 1'b0;  b64.len_i = '0;  b64.data_i = '0;
    b64.msg_len_i = '0;  b64.ov_valid_i = 1'b0; b64.ov_len_i = '0; b64.ov_data_i = '0;
    b64.ov_msg_len_i = '0;
    b128.valid_i = 1'b0; b128.start_i = 1'b0; b128.len_i = '0; b128.data_i = '0;
    b128.msg_len_i = '0; b128.ov_valid_i = 1'b0; b128.ov_len_i = '0; b128.ov_data_i = '0;
    b128.ov_msg_len_i = '0;
    step();
  endtask

  task automatic beat64(input logic s, input int len, input logic [63:0] d, input int mlen,
                        input logic ov, input int ovl, input logic [47:0] od, input int ovm);
    b64.valid_i = 1'b1; b64.start_i = s; b64.len_i = 4'(len); b64.data_i = d;
    b64.msg_len_i = 16'(mlen); b64.ov_valid_i = ov; b64.ov_len_i = 3'(ovl);
    b64.ov_data_i = od; b64.ov_msg_len_i = 16'(ovm);
    step();
  endtask

  task automatic beat128(input int len, input logic [127:0] d, input int mlen,
                         input int ovl, input logic [111:0] od, input int ovm);
    b128.valid_i = 1'b1; b128.start_i = 1'b1; b128.len_i = 5'(len); b128.data_i = d;
    b128.msg_len_i = 16'(mlen); b128.ov_valid_i = 1'b1; b128.ov_len_i = 4'(ovl);
    b128.ov_data_i = od; b128.ov_msg_len_i = 16'(ovm);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    idle();
    checks++;
    if ({obs64(), b64.err_o, b64.err_code_o, st64} !== '0) begin
      failures++;
      $display("FAIL reset64 got=%h exp=0", {obs64(), b64.err_o, b64.err_code_o, st64});
    end
    checks++;
    if ({obs128(), b128.err_o, b128.err_code_o, st128} !== '0) begin
      failures++;
      $display("FAIL reset128 got=%h exp=0", {obs128(), b128.err_o, b128.err_code_o, st128});
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_basic();
    bq_t q;
    beat64(1'b1, 8, 64'hFFFFFFFF_FFFFFF47, 21, 1'b0, 0, '0, 0);
    beat64(1'b0, 8, 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0, 0, '0, 0);
    checks++;
    if (b64.msg_valid_o !== 1'b0) begin
      failures++; $display("FAIL basic_early got=%b exp=0", b64.msg_valid_o);
    end
    beat64(1'b0, 5, 64'h000000FF_FFFFFFFF, 0, 1'b1, 1, 48'h41, 36);
    q = {8'h47};
    for (int i = 0; i < 20; i++) q.push_back(8'hFF);
    checks++;
    if (obs64() !== exp_msg(q)) begin
      failures++; $display("FAIL basic_g got=%h exp=%h", obs64(), exp_msg(q));
    end
    for (int i = 0; i < 4; i++) beat64(1'b0, 8, 64'hDDCCBBAA_DDCCBBAA, 0, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.err_o} !== 2'b00) begin
      failures++; $display("FAIL basic_mid got=%b exp=00", {b64.msg_valid_o, b64.err_o});
    end
    beat64(1'b0, 3, 64'h00000000_00EEEEEE, 0, 1'b0, 0, '0, 0);
    q = {8'h41};
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC); q.push_back(8'hDD);
    end
    for (int i = 0; i < 3; i++) q.push_back(8'hEE);
    checks++;
    if (obs64() !== exp_msg(q)) begin
      failures++; $display("FAIL basic_a got=%h exp=%h", obs64(), exp_msg(q));
    end
    idle();
    checks++;
    if (b64.msg_valid_o !== 1'b0) begin
      failures++; $display("FAIL basic_after got=%b exp=0", b64.msg_valid_o);
    end
  endtask

  // Shared 12-byte message: type 0x53 followed by bytes 01..0B.
  task automatic send12_check(input string name);
    bq_t q;
    beat64(1'b1, 8, 64'h07060504_03020153, 12, 1'b0, 0, '0, 0);
    beat64(1'b0, 4, 64'h00000000_0B0A0908, 0, 1'b0, 0, '0, 0);
    q = {8'h53};
    for (int i = 1; i < 12; i++) q.push_back(8'(i));
    checks++;
    if (obs64() !== exp_msg(q)) begin
      failures++; $display("FAIL %s got=%h exp=%h", name, obs64(), exp_msg(q));
    end
  endtask

  task automatic test_oversize();
    beat64(1'b1, 8, 64'h11111111_11111151, 51, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.err_o, b64.err_code_o} !== 5'b0_1_001) begin
      failures++; $display("FAIL oversize_err got=%b exp=01001", {b64.msg_valid_o, b64.err_o, b64.err_code_o});
    end
    for (int i = 0; i < 2; i++) begin
      beat64(1'b0, 8, 64'h22222222_22222222, 0, 1'b0, 0, '0, 0);
      checks++;
      if ({b64.msg_valid_o, b64.err_o} !== 2'b00) begin
        failures++; $display("FAIL oversize_drop got=%b exp=00", {b64.msg_valid_o, b64.err_o});
      end
    end
    send12_check("oversize_next");
    idle();
  endtask

  task automatic test_trunc();
    beat64(1'b1, 8, 64'h33333333_33333354, 36, 1'b0, 0, '0, 0);
    beat64(1'b0, 8, 64'h33333333_33333333, 0, 1'b0, 0, '0, 0);
    beat64(1'b1, 8, 64'h07060504_03020153, 12, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.err_o, b64.err_code_o} !== 5'b0_1_010) begin
      failures++; $display("FAIL trunc_err got=%b exp=01010", {b64.msg_valid_o, b64.err_o, b64.err_code_o});
    end
    beat64(1'b0, 4, 64'h00000000_0B0A0908, 0, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.msg_len_o, b64.err_o} !== {1'b1, 6'd12, 1'b0}) begin
      failures++; $display("FAIL trunc_new got=%h exp=%h", {b64.msg_valid_o, b64.msg_len_o, b64.err_o}, {1'b1, 6'd12, 1'b0});
    end
    idle();
    checks++;
    if (b64.msg_valid_o !== 1'b0) begin
      failures++; $display("FAIL trunc_after got=%b exp=0", b64.msg_valid_o);
    end
  endtask

  task automatic test_overrun();
    beat64(1'b1, 8, 64'h07060504_03020153, 12, 1'b0, 0, '0, 0);
    beat64(1'b0, 8, 64'h0F0E0D0C_0B0A0908, 0, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.err_o, b64.err_code_o} !== 5'b0_1_011) begin
      failures++; $display("FAIL overrun_err got=%b exp=01011", {b64.msg_valid_o, b64.err_o, b64.err_code_o});
    end
    idle();
    checks++;
    if ({b64.msg_valid_o, b64.err_o, st64} !== 4'b0000) begin
      failures++; $display("FAIL overrun_after got=%b exp=0000", {b64.msg_valid_o, b64.err_o, st64});
    end
  endtask

  task automatic test_ov_illegal();
    bq_t q;
    beat64(1'b1, 8, 64'h07060504_03020154, 20, 1'b1, 2, 48'h0000_00005A58, 5);
    checks++;
    if ({b64.msg_valid_o, b64.err_o, b64.err_code_o} !== 5'b0_1_100) begin
      failures++; $display("FAIL ov_ill_err got=%b exp=01100", {b64.msg_valid_o, b64.err_o, b64.err_code_o});
    end
    beat64(1'b0, 8, 64'h0F0E0D0C_0B0A0908, 0, 1'b0, 0, '0, 0);
    beat64(1'b0, 4, 64'h00000000_13121110, 0, 1'b0, 0, '0, 0);
    q = {8'h54};
    for (int i = 1; i < 20; i++) q.push_back(8'(i));
    checks++;
    if (obs64() !== exp_msg(q)) begin
      failures++; $display("FAIL ov_ill_msg got=%h exp=%h", obs64(), exp_msg(q));
    end
    idle();
  endtask

  task automatic test_reset_mid();
    beat64(1'b1, 8, 64'h44444444_44444455, 36, 1'b0, 0, '0, 0);
    beat64(1'b0, 8, 64'h44444444_44444444, 0, 1'b0, 0, '0, 0);
    reset = 1'b1;
    idle();
    checks++;
    if ({obs64(), b64.err_o, b64.err_code_o, st64} !== '0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", {obs64(), b64.err_o, b64.err_code_o, st64});
    end
    reset = 1'b0;
    beat64(1'b0, 8, 64'h66666666_66666666, 0, 1'b0, 0, '0, 0);
    beat64(1'b1, 8, 64'h07060504_03020153, 12, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.err_o} !== 2'b00) begin
      failures++; $display("FAIL reset_restart got=%b exp=00", {b64.msg_valid_o, b64.err_o});
    end
    beat64(1'b0, 4, 64'h00000000_0B0A0908, 0, 1'b0, 0, '0, 0);
    checks++;
    if ({b64.msg_valid_o, b64.msg_type_o, b64.msg_len_o} !== {1'b1, 8'h53, 6'd12}) begin
      failures++; $display("FAIL reset_fresh got=%h exp=%h", {b64.msg_valid_o, b64.msg_type_o, b64.msg_len_o}, {1'b1, 8'h53, 6'd12});
    end
    idle();
  endtask

  task automatic test_back_to_back();
    bq_t qa, qb, qc, qd;
    qa = mk12(8'h50, 8'h10);
    qb = mk12(8'h51, 8'h20);
    qc = mk12(8'h52, 8'h30);
    qd = mk12(8'h53, 8'h40);
    beat128(12, pack128(qa), 12, 12, 112'(pack128(qb)), 12);
    checks++;
    if ({obs128(), b128.err_o} !== {exp_msg(qa), 1'b0}) begin
      failures++; $display("FAIL b2b_first got=%h exp=%h", obs128(), exp_msg(qa));
    end
    beat128(12, pack128(qc), 12, 12, 112'(pack128(qd)), 12);
    checks++;
    if (obs128() !== exp_msg(qb)) begin
      failures++; $display("FAIL b2b_second got=%h exp=%h", obs128(), exp_msg(qb));
    end
    checks++;
    if ({b128.err_o, b128.err_code_o} !== 4'b1_101) begin
      failures++; $display("FAIL b2b_qfull got=%b exp=1101", {b128.err_o, b128.err_code_o});
    end
    idle();
    checks++;
    if ({obs128(), b128.err_o} !== {exp_msg(qc), 1'b0}) begin
      failures++; $display("FAIL b2b_third got=%h exp=%h", obs128(), exp_msg(qc));
    end
    idle();
    checks++;
    if (b128.msg_valid_o !== 1'b0) begin
      failures++; $display("FAIL b2b_dropped got=%b exp=0", b128.msg_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oversize();
    test_trunc();
    test_overrun();
    test_ov_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
